// File: rtl/match_accum7.sv
// Correlation accumulator: popcounts 7 sign-match bits per accepted word, integrates
// ACC_LEN words, then offers the signed result 2*ones - 7*ACC_LEN on a dump port.
module match_accum7 #(
    parameter int ACC_LEN   = 1023,
    parameter int ACC_WIDTH = 16,
    parameter int CNT_WIDTH = 12
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        continuous,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [6:0]                  match,
    output logic                        dump_valid,
    input  logic                        dump_ready,
    output logic signed [ACC_WIDTH-1:0] dump_sum,
    output logic                        busy
);

    // Both ports are valid/ready: a transfer happens on a rising edge where valid and
    // ready are both high. dump_valid never depends on dump_ready; in_ready is low
    // whenever start, stop or rst is asserted so a word is never half-accepted.

    localparam int ONES_W = $clog2(7 * ACC_LEN + 1);
    localparam int SUM_W  = ONES_W + 2;
    localparam logic [SUM_W-1:0]     BIAS     = SUM_W'(7 * ACC_LEN);
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(ACC_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DUMP  = 2'd2
    } state_t;

    state_t                state;
    logic [ONES_W-1:0]     ones_acc;
    logic [CNT_WIDTH-1:0]  word_cnt;

    logic [1:0]            s01, s23, s45;
    logic [2:0]            s0123, s456, pc;
    logic [ONES_W-1:0]     ones_next;
    logic signed [SUM_W-1:0] corr;
    logic                  accept;
    logic                  last_word;

    // Balanced adder7 tree; the final sum tops out at 7 so 3 bits suffice.
    assign s01   = {1'b0, match[0]} + {1'b0, match[1]};
    assign s23   = {1'b0, match[2]} + {1'b0, match[3]};
    assign s45   = {1'b0, match[4]} + {1'b0, match[5]};
    assign s0123 = {1'b0, s01} + {1'b0, s23};
    assign s456  = {1'b0, s45} + {2'b00, match[6]};
    assign pc    = s0123 + s456;

    assign in_ready  = (state == ACCUM) && !start && !stop && !rst;
    assign accept    = in_valid && in_ready;
    assign last_word = (word_cnt == LAST_CNT);
    assign busy      = (state != IDLE);

    // Correlation of the integration including the word being accepted now.
    assign ones_next = ones_acc + ONES_W'(pc);
    assign corr      = signed'({1'b0, ones_next, 1'b0} - BIAS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ones_acc   <= '0;
            word_cnt   <= '0;
            dump_valid <= 1'b0;
            dump_sum   <= '0;
        end else if (stop) begin
            state      <= IDLE;
            ones_acc   <= '0;
            word_cnt   <= '0;
            dump_valid <= 1'b0;
        end else if (start) begin
            // Restart from any state; a pending dump is discarded.
            state      <= ACCUM;
            ones_acc   <= '0;
            word_cnt   <= '0;
            dump_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    dump_valid <= 1'b0;
                end
                ACCUM: begin
                    if (accept) begin
                        if (last_word) begin
                            dump_sum   <= ACC_WIDTH'(corr);
                            dump_valid <= 1'b1;
                            ones_acc   <= '0;
                            word_cnt   <= '0;
                            state      <= DUMP;
                        end else begin
                            ones_acc <= ones_next;
                            word_cnt <= word_cnt + CNT_WIDTH'(1);
                        end
                    end
                end
                DUMP: begin
                    if (dump_ready) begin
                        dump_valid <= 1'b0;
                        state      <= continuous ? ACCUM : IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    dump_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_match_accum7.sv
// Bench for match_accum7: three instances (ACC_LEN 1023, 4 and 1) driven by directed
// sequences, a vector table and a randomized run against a word-level reference model.
module tb_match_accum7;

    localparam int N    = 3;
    localparam int LEN0 = 1023;
    localparam int LEN1 = 4;
    localparam int LEN2 = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      start, stop, continuous, in_valid, in_ready;
    logic [N-1:0]      dump_valid, dump_ready, busy;
    logic [6:0]        match [N];
    logic signed [15:0] dump_sum [N];

    int checks = 0;
    int errors = 0;
    logic signed [15:0] exp_q[$];

    typedef struct {
        logic [6:0] m;
        int         exp_sum;
    } vec_t;

    vec_t vecs [10];

    always #5 clk = ~clk;

    match_accum7 #(.ACC_LEN(LEN0), .ACC_WIDTH(16), .CNT_WIDTH(12)) dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .stop(stop[0]),
        .continuous(continuous[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .match(match[0]), .dump_valid(dump_valid[0]), .dump_ready(dump_ready[0]),
        .dump_sum(dump_sum[0]), .busy(busy[0]));

    match_accum7 #(.ACC_LEN(LEN1), .ACC_WIDTH(16), .CNT_WIDTH(12)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .stop(stop[1]),
        .continuous(continuous[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .match(match[1]), .dump_valid(dump_valid[1]), .dump_ready(dump_ready[1]),
        .dump_sum(dump_sum[1]), .busy(busy[1]));

    match_accum7 #(.ACC_LEN(LEN2), .ACC_WIDTH(16), .CNT_WIDTH(12)) dut2 (
        .clk(clk), .rst(rst), .start(start[2]), .stop(stop[2]),
        .continuous(continuous[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .match(match[2]), .dump_valid(dump_valid[2]), .dump_ready(dump_ready[2]),
        .dump_sum(dump_sum[2]), .busy(busy[2]));

    // ---------------- clock / reset helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic pulse_start(input int d);
        start[d] = 1'b1;
        cyc();
        start[d] = 1'b0;
    endtask

    task automatic run_words(input int d, input int n, input logic [6:0] m, output int early);
        int guard;
        early = 0;
        for (int i = 0; i < n; i++) begin
            guard = 0;
            in_valid[d] = 1'b1;
            match[d]    = m;
            #1;
            while (!in_ready[d] && guard < 50) begin
                cyc();
                guard++;
            end
            if (guard >= 50) begin
                check("in_ready_timeout", 0, 1);
                break;
            end
            if (dump_valid[d]) early++;
            cyc();
        end
        in_valid[d] = 1'b0;
    endtask

    task automatic take_dump(input int d, input int exp, input string name);
        int guard;
        guard = 0;
        while (!dump_valid[d] && guard < 20) begin
            cyc();
            guard++;
        end
        check({name, "_valid"}, int'(dump_valid[d]), 1);
        check(name, int'(dump_sum[d]), exp);
        dump_ready[d] = 1'b1;
        cyc();
        dump_ready[d] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int   early;
        bit   m_accum, m_wait;
        int   m_cnt, m_sum, n_dumps;
        logic [6:0] seq3 [4];

        vecs[0] = '{7'h00, -7};
        vecs[1] = '{7'h01, -5};
        vecs[2] = '{7'h40, -5};
        vecs[3] = '{7'h03, -3};
        vecs[4] = '{7'h15, -1};
        vecs[5] = '{7'h0F,  1};
        vecs[6] = '{7'h55,  1};
        vecs[7] = '{7'h1F,  3};
        vecs[8] = '{7'h3F,  5};
        vecs[9] = '{7'h7F,  7};

        rst = 1'b1;
        start = '0; stop = '0; continuous = '0; in_valid = '0; dump_ready = '0;
        for (int d = 0; d < N; d++) match[d] = '0;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        for (int d = 0; d < N; d++) begin
            check($sformatf("reset_dump_valid%0d", d), int'(dump_valid[d]), 0);
            check($sformatf("reset_dump_sum%0d", d), int'(dump_sum[d]), 0);
            check($sformatf("reset_in_ready%0d", d), int'(in_ready[d]), 0);
            check($sformatf("reset_busy%0d", d), int'(busy[d]), 0);
        end

        // Full-length integrations, single shot.
        continuous[0] = 1'b0;
        pulse_start(0);
        run_words(0, LEN0, 7'h7F, early);
        check("t1_early_dump", early, 0);
        check("t1_latency", int'(dump_valid[0]), 1);
        check("t1_in_ready_in_dump", int'(in_ready[0]), 0);
        take_dump(0, 7161, "t1_sum_all_ones");
        check("t1_idle_after", int'(busy[0]), 0);

        pulse_start(0);
        run_words(0, LEN0, 7'h00, early);
        take_dump(0, -7161, "t2_sum_all_zero");
        pulse_start(0);
        run_words(0, LEN0, 7'h0F, early);
        take_dump(0, 1023, "t2_sum_pc4");

        // start mid-integration restarts the count; the offered word is dropped.
        pulse_start(0);
        run_words(0, 500, 7'h7F, early);
        in_valid[0] = 1'b1;
        match[0]    = 7'h7F;
        start[0]    = 1'b1;
        #1;
        check("t5_start_drops_word", int'(in_ready[0]), 0);
        cyc();
        start[0] = 1'b0;
        run_words(0, LEN0 - 1, 7'h00, early);
        check("t5_early_dump", early, 0);
        check("t5_no_dump_yet", int'(dump_valid[0]), 0);
        run_words(0, 1, 7'h00, early);
        take_dump(0, -7161, "t5_sum_after_restart");

        // Continuous mode with no gap after the dump handshake.
        continuous[1] = 1'b1;
        seq3[0] = 7'h7F; seq3[1] = 7'h00; seq3[2] = 7'h07; seq3[3] = 7'h1F;
        pulse_start(1);
        for (int i = 0; i < 4; i++) run_words(1, 1, seq3[i], early);
        check("t3_latency", int'(dump_valid[1]), 1);
        check("t3_sum1", int'(dump_sum[1]), 2);
        dump_ready[1] = 1'b1;
        in_valid[1]   = 1'b1;
        match[1]      = 7'h01;
        #1;
        check("t3_stall_in_dump", int'(in_ready[1]), 0);
        cyc();
        dump_ready[1] = 1'b0;
        check("t3_dump_taken", int'(dump_valid[1]), 0);
        check("t3_no_gap", int'(in_ready[1]), 1);
        cyc();
        run_words(1, 3, 7'h01, early);
        check("t3_latency2", int'(dump_valid[1]), 1);

        // Backpressure: result held, upstream stalled.
        for (int i = 0; i < 10; i++) begin
            in_valid[1] = 1'b1;
            match[1]    = 7'h7F;
            #1;
            check("t4_hold_valid", int'(dump_valid[1]), 1);
            check("t4_hold_sum", int'(dump_sum[1]), -20);
            check("t4_stall", int'(in_ready[1]), 0);
            cyc();
        end
        in_valid[1]   = 1'b0;
        dump_ready[1] = 1'b1;
        cyc();
        dump_ready[1] = 1'b0;
        check("t4_one_handshake", int'(dump_valid[1]), 0);
        check("t4_back_to_accum", int'(in_ready[1]), 1);
        cyc();
        check("t4_no_second_dump", int'(dump_valid[1]), 0);
        run_words(1, LEN1, 7'h7F, early);
        take_dump(1, 28, "t4_next_sum");

        // stop / rst in ACCUM and DUMP.
        run_words(1, 2, 7'h7F, early);
        stop[1] = 1'b1;
        cyc();
        stop[1] = 1'b0;
        check("t6_stop_accum_busy", int'(busy[1]), 0);
        check("t6_stop_accum_valid", int'(dump_valid[1]), 0);
        check("t6_stop_accum_ready", int'(in_ready[1]), 0);

        pulse_start(1);
        run_words(1, LEN1, 7'h7F, early);
        stop[1] = 1'b1;
        cyc();
        stop[1] = 1'b0;
        check("t6_stop_dump_busy", int'(busy[1]), 0);
        check("t6_stop_dump_valid", int'(dump_valid[1]), 0);

        pulse_start(1);
        run_words(1, LEN1, 7'h7F, early);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("t6_rst_dump_busy", int'(busy[1]), 0);
        check("t6_rst_dump_valid", int'(dump_valid[1]), 0);
        check("t6_rst_dump_sum", int'(dump_sum[1]), 0);

        pulse_start(1);
        run_words(1, 2, 7'h7F, early);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("t6_rst_accum_busy", int'(busy[1]), 0);
        check("t6_rst_accum_ready", int'(in_ready[1]), 0);

        // start while a dump is pending discards it.
        pulse_start(1);
        run_words(1, LEN1, 7'h7F, early);
        pulse_start(1);
        check("t6_start_dump_discard", int'(dump_valid[1]), 0);
        check("t6_start_dump_busy", int'(busy[1]), 1);
        run_words(1, LEN1, 7'h00, early);
        take_dump(1, -28, "t6_sum_after_discard");
        stop[1]  = 1'b1;
        start[1] = 1'b1;
        cyc();
        stop[1]  = 1'b0;
        start[1] = 1'b0;
        check("t6_stop_beats_start", int'(busy[1]), 0);

        // ACC_LEN=1 vector table.
        continuous[2] = 1'b1;
        pulse_start(2);
        foreach (vecs[i]) begin
            run_words(2, 1, vecs[i].m, early);
            check($sformatf("tbl_latency%0d", i), int'(dump_valid[2]), 1);
            take_dump(2, vecs[i].exp_sum, $sformatf("tbl_sum%0d", i));
        end

        // Randomized gaps and backpressure against a word-level model.
        pulse_start(1);
        m_accum = 1'b1; m_wait = 1'b0; m_cnt = 0; m_sum = 0; n_dumps = 0;
        exp_q.delete();
        for (int c = 0; c < 3000; c++) begin
            in_valid[1]   = ($urandom_range(0, 9) < 6);
            match[1]      = 7'($urandom_range(0, 127));
            dump_ready[1] = ($urandom_range(0, 9) < 5);
            #1;
            check("rnd_in_ready", int'(in_ready[1]), int'(m_accum));
            check("rnd_dump_valid", int'(dump_valid[1]), int'(m_wait));
            if (m_accum && in_valid[1]) begin
                m_sum += $countones(match[1]);
                m_cnt++;
                if (m_cnt == LEN1) begin
                    exp_q.push_back(16'(2 * m_sum - 7 * LEN1));
                    m_sum = 0; m_cnt = 0; m_accum = 1'b0; m_wait = 1'b1;
                end
            end else if (m_wait && dump_ready[1]) begin
                if (exp_q.size() > 0) check("rnd_sum", int'(dump_sum[1]), int'(exp_q.pop_front()));
                n_dumps++;
                m_wait = 1'b0; m_accum = 1'b1;
            end
            cyc();
        end
        in_valid[1]   = 1'b0;
        dump_ready[1] = 1'b0;
        check("rnd_dump_count_ok", int'(n_dumps > 50), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
